// File: rtl/wb_burst_arb_pkg.sv
// Shared types and helpers for the burst-aware wishbone round-robin arbiter.
package wb_arb_pkg;

    localparam int NUM_MST = 4;
    localparam int GNT_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWN     = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    // Turn an encoded owner index into the one-hot select used by the slave port mux.
    function automatic logic [NUM_MST-1:0] gnt_onehot(input logic [GNT_W-1:0] idx);
        logic [NUM_MST-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/wb_burst_arb_pick.sv
// Round-robin pick: first requester after the last owner, last owner lowest priority.
module wb_rr_pick
    import wb_arb_pkg::*;
(
    input  logic [NUM_MST-1:0] req,
    input  logic [GNT_W-1:0]   last,
    output logic               any,
    output logic [GNT_W-1:0]   idx
);

    logic [GNT_W-1:0] cand;

    // Scan from furthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        any  = 1'b0;
        idx  = last;
        cand = last;
        for (int k = NUM_MST; k >= 1; k--) begin
            cand = last + GNT_W'(k);
            if (req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/wb_burst_arb.sv
// Burst-aware round-robin arbiter sharing one wishbone slave port among 4 masters.
// A grant is held for a whole transfer and released on last-ack, abort or watchdog.
module wb_burst_arb
    import wb_arb_pkg::*;
#(
    parameter int TOUT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_n,
    input  logic [TOUT_W-1:0]  cfg_tout,
    input  logic [NUM_MST-1:0] req_i,
    input  logic               ack_i,
    input  logic               lack_i,
    output logic [GNT_W-1:0]   gnt_o,
    output logic               gnt_vld_o,
    output logic [NUM_MST-1:0] gnt_oh_o,
    output logic               tout_err_o,
    output logic [GNT_W-1:0]   tout_id_o
);

    arb_state_t        state_q;
    logic [GNT_W-1:0]  last_q;
    logic [TOUT_W-1:0] cnt_q;
    logic              pick_any;
    logic [GNT_W-1:0]  pick_idx;
    logic              tout_hit;

    // Shared by the IDLE and RELEASE arbitration paths; last_q is already updated in RELEASE.
    wb_rr_pick u_pick (
        .req  (req_i),
        .last (last_q),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // Watchdog fires on the cycle the counter reaches the limit with no ack; zero disables it.
    always_comb begin
        tout_hit = (cfg_tout != '0) && (cnt_q == (cfg_tout - TOUT_W'(1))) && !ack_i;
    end

    // Arbiter FSM with registered grant, watchdog counter and error outputs.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_q     <= GNT_W'(NUM_MST - 1);
            cnt_q      <= '0;
            gnt_o      <= '0;
            gnt_vld_o  <= 1'b0;
            gnt_oh_o   <= '0;
            tout_err_o <= 1'b0;
            tout_id_o  <= '0;
        end else begin
            tout_err_o <= 1'b0;
            case (state_q)
                IDLE, RELEASE: begin
                    cnt_q <= '0;
                    if (pick_any) begin
                        state_q   <= OWN;
                        gnt_o     <= pick_idx;
                        gnt_vld_o <= 1'b1;
                        gnt_oh_o  <= gnt_onehot(pick_idx);
                    end else begin
                        state_q <= IDLE;
                    end
                end
                OWN: begin
                    if (lack_i || !req_i[gnt_o] || tout_hit) begin
                        state_q   <= RELEASE;
                        last_q    <= gnt_o;
                        cnt_q     <= '0;
                        gnt_vld_o <= 1'b0;
                        gnt_oh_o  <= '0;
                        if (!lack_i && req_i[gnt_o]) begin
                            tout_err_o <= 1'b1;
                            tout_id_o  <= gnt_o;
                        end
                    end else if (ack_i) begin
                        cnt_q <= '0;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + TOUT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_arb.sv
// Self-checking bench for wb_burst_arb: fixed vector table, directed corner
// sequences and randomized traffic against a behavioural round-robin model.
module tb_wb_burst_arb;

    logic       clk_i;
    logic       rst_n;
    logic [7:0] cfg_tout;
    logic [3:0] req_i;
    logic       ack_i;
    logic       lack_i;
    logic [1:0] gnt_o;
    logic       gnt_vld_o;
    logic [3:0] gnt_oh_o;
    logic       tout_err_o;
    logic [1:0] tout_id_o;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: who owns the bus, whom to skip next, cycles since ack.
    bit m_busy;
    bit m_vld;
    bit m_err;
    int m_gnt;
    int m_last;
    int m_cnt;
    int m_id;

    typedef struct {
        logic [3:0] req;
        logic       ack;
        logic       lack;
        logic       vld;
        logic [1:0] gnt;
        logic [3:0] oh;
    } vec_t;

    vec_t tbl[13];

    wb_burst_arb #(.TOUT_W(8)) dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .cfg_tout   (cfg_tout),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .lack_i     (lack_i),
        .gnt_o      (gnt_o),
        .gnt_vld_o  (gnt_vld_o),
        .gnt_oh_o   (gnt_oh_o),
        .tout_err_o (tout_err_o),
        .tout_id_o  (tout_id_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= 4; k++) begin
            int c;
            c = (last + k) % 4;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_vld = 0; m_err = 0;
        m_gnt  = 0; m_last = 3; m_cnt = 0; m_id = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int p;
        bit tmo;
        m_err = 0;
        if (m_busy) begin
            tmo = (cfg_tout != 0) && (m_cnt == int'(cfg_tout) - 1) && !ack_i;
            if (lack_i || !req_i[m_gnt] || tmo) begin
                if (!lack_i && req_i[m_gnt]) begin
                    m_err = 1;
                    m_id  = m_gnt;
                end
                m_busy = 0; m_vld = 0; m_last = m_gnt; m_cnt = 0;
            end else if (ack_i) begin
                m_cnt = 0;
            end else if (m_cnt < 255) begin
                m_cnt = m_cnt + 1;
            end
        end else begin
            p = rr_pick(req_i, m_last);
            if (p >= 0) begin
                m_busy = 1; m_vld = 1; m_gnt = p; m_cnt = 0;
            end
        end
    endtask

    function automatic logic [10:0] model_vec();
        logic [3:0] oh;
        logic [1:0] g;
        logic [1:0] id;
        g  = m_gnt[1:0];
        id = m_id[1:0];
        oh = m_vld ? (4'b0001 << g) : 4'b0000;
        return {g, m_vld, oh, m_err, id};
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string name);
        check_val(name, {21'd0, gnt_o, gnt_vld_o, gnt_oh_o, tout_err_o, tout_id_o}, {21'd0, model_vec()});
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic a, input logic l);
        req_i  = r;
        ack_i  = a;
        lack_i = l;
        @(posedge clk_i);
        model_step();
        #1;
    endtask

    initial begin
        logic [3:0] r;
        rst_n    = 1'b0;
        cfg_tout = 8'd0;
        req_i    = 4'b0000;
        ack_i    = 1'b0;
        lack_i   = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        check_val("reset_outputs", {21'd0, gnt_o, gnt_vld_o, gnt_oh_o, tout_err_o, tout_id_o}, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;

        // Round-robin order 0,1,2,3,0 with a one-cycle gap, then abort and sole-requester regrant.
        tbl[0]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[2]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0010};
        tbl[3]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 2'd1, 4'b0000};
        tbl[4]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0100};
        tbl[5]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000};
        tbl[6]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd3, 4'b1000};
        tbl[7]  = '{4'b1111, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000};
        tbl[8]  = '{4'b1111, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        tbl[9]  = '{4'b1110, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        tbl[10] = '{4'b0001, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0001};
        tbl[11] = '{4'b0001, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000};
        tbl[12] = '{4'b0000, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000};
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].req, tbl[i].ack, tbl[i].lack);
            check_val($sformatf("tbl%0d", i), {25'd0, gnt_o, gnt_vld_o, gnt_oh_o},
                      {25'd0, tbl[i].gnt, tbl[i].vld, tbl[i].oh});
            checkOutput($sformatf("tbl%0d_model", i));
        end

        // Master 2 holds a burst of 8 acks while master 1 (and optionally 3) waits.
        for (int m3 = 0; m3 < 2; m3++) begin
            r = (m3 != 0) ? 4'b1110 : 4'b0110;
            applyStimulus(4'b0100, 1'b0, 1'b0);
            check_val("burst_grant2", {30'd0, gnt_o}, 32'd2);
            for (int i = 0; i < 8; i++) begin
                applyStimulus(r, 1'b1, (i == 7));
                if (i < 7) check_val($sformatf("burst_hold%0d", i), {29'd0, gnt_o, gnt_vld_o}, {29'd0, 2'd2, 1'b1});
                else       check_val("burst_release", {29'd0, gnt_o, gnt_vld_o}, {29'd0, 2'd2, 1'b0});
            end
            applyStimulus(r, 1'b0, 1'b0);
            check_val($sformatf("burst_next_m3_%0d", m3), {29'd0, gnt_o, gnt_vld_o},
                      {29'd0, (m3 != 0) ? 2'd3 : 2'd1, 1'b1});
            checkOutput("burst_next_model");
            applyStimulus(4'b0000, 1'b0, 1'b0);
            applyStimulus(4'b0000, 1'b0, 1'b0);
        end

        // Watchdog: owner 1 never acked, limit 5.
        cfg_tout = 8'd5;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        check_val("tout_grant1", {29'd0, gnt_o, gnt_vld_o}, {29'd0, 2'd1, 1'b1});
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'b0010, 1'b0, 1'b0);
            if (i < 4) check_val($sformatf("tout_wait%0d", i), {30'd0, tout_err_o, gnt_vld_o}, {30'd0, 1'b0, 1'b1});
            else       check_val("tout_fire", {28'd0, tout_err_o, tout_id_o, gnt_vld_o}, {28'd0, 1'b1, 2'd1, 1'b0});
            checkOutput($sformatf("tout_model%0d", i));
        end
        applyStimulus(4'b0000, 1'b0, 1'b0);
        check_val("tout_pulse_end", {31'd0, tout_err_o}, 32'd0);

        // Watchdog disabled: grant held well past counter saturation.
        cfg_tout = 8'd0;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        repeat (300) applyStimulus(4'b0010, 1'b0, 1'b0);
        check_val("no_tout_hold", {28'd0, gnt_o, gnt_vld_o, tout_err_o}, {28'd0, 2'd1, 1'b1, 1'b0});
        cfg_tout = 8'd2;
        applyStimulus(4'b0010, 1'b0, 1'b0);
        check_val("tout_after_sat", {31'd0, gnt_vld_o}, {31'd1});
        checkOutput("tout_after_sat_model");
        cfg_tout = 8'd0;
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Owner aborts mid-burst: release without error.
        cfg_tout = 8'd4;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        check_val("abort_release", {30'd0, gnt_vld_o, tout_err_o}, 32'd0);
        applyStimulus(4'b0000, 1'b0, 1'b0);

        // Last-ack coincides with the watchdog limit: lack wins, no error.
        cfg_tout = 8'd3;
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b1);
        check_val("lack_beats_tout", {30'd0, gnt_vld_o, tout_err_o}, 32'd0);
        checkOutput("lack_beats_tout_model");
        applyStimulus(4'b0000, 1'b0, 1'b0);
        cfg_tout = 8'd0;

        // Asynchronous reset while master 3 owns the bus, then pointer restarts at 0.
        applyStimulus(4'b1000, 1'b0, 1'b0);
        check_val("rst_pre_owner3", {29'd0, gnt_o, gnt_vld_o}, {29'd0, 2'd3, 1'b1});
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_async", {21'd0, gnt_o, gnt_vld_o, gnt_oh_o, tout_err_o, tout_id_o}, 32'd0);
        req_i = 4'b0000;
        @(negedge clk_i);
        rst_n = 1'b1;
        applyStimulus(4'b1001, 1'b0, 1'b0);
        check_val("rst_ptr_restart", {29'd0, gnt_o, gnt_vld_o}, {29'd0, 2'd0, 1'b1});
        checkOutput("rst_ptr_model");

        // Randomized traffic with sticky requests and occasional limit changes.
        r = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) cfg_tout = 8'($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
            applyStimulus(r, ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            checkOutput($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_burst_arb.md
Name: wb_burst_arb

Overview:
- Round-robin arbiter that shares one wishbone slave port between 4 masters.
- Burst-aware: a grant is held for a whole transfer (single or burst) and released on the slave's last-ack (lack), on requester abort, or on a watchdog timeout.
- Sits between the per-master qualified strobes and the grant-driven master mux / staging FF inside the slave port; gnt_o steers both the write mux and the read-return demux.

Parameters:
- NUM_MST, 4, number of requesters. Fixed at 4 in this revision; grant encoding is 2 bits.
- TOUT_W, 8, width of the watchdog counter and of cfg_tout.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  reset, asynchronous assert, active-low
- cfg_tout  in  TOUT_W  watchdog limit in cycles without ack; 0 disables the watchdog
- req_i  in  4  per-master request (stb already qualified by target id and !lack by the caller)
- ack_i  in  1  slave ack for the current owner
- lack_i  in  1  slave last-ack; ends the burst
- gnt_o  out  2  encoded owner index
- gnt_vld_o  out  1  grant valid; owner may drive the bus
- gnt_oh_o  out  4  one-hot owner; all zero when gnt_vld_o=0
- tout_err_o  out  1  one-cycle pulse on watchdog release
- tout_id_o  out  2  owner index captured at the last timeout

Behaviour:
- Reset values: gnt_o=0, gnt_vld_o=0, gnt_oh_o=0, tout_err_o=0, tout_id_o=0, last-owner pointer=3 (so the first search starts at master 0), counter=0, state IDLE.
- All outputs are registered; there is no combinational path from req_i, ack_i or lack_i to any output.
- Pick function: the first asserted req_i at index (last+1), (last+2), (last+3), (last+4) mod 4.
  - The last owner has the lowest priority, but it is re-granted if it is the sole requester.

State machine:
- IDLE:
  - Any req_i=1 at cycle N -> gnt_o=pick and gnt_vld_o=1 at N+1; go to OWN.
  - Otherwise stay in IDLE. gnt_o keeps the previous owner so late read data still routes correctly.
- OWN:
  - Hold gnt_o stable; counter increments every cycle and clears on ack_i=1.
  - Exit conditions, in priority order:
    1. lack_i=1 -> RELEASE (normal end of transfer).
    2. req_i[gnt_o]=0 -> RELEASE (abort).
    3. cfg_tout!=0, counter==cfg_tout-1 and ack_i=0 -> RELEASE; tout_err_o=1 for one cycle; tout_id_o=gnt_o.
  - lack_i asserted in the same cycle as a timeout: lack wins, no error.
- RELEASE (exactly one cycle):
  - gnt_vld_o=0, gnt_oh_o=0, gnt_o still holds the old owner, last pointer = gnt_o, counter cleared.
  - Arbitrate using the updated pointer: any request -> OWN with the new gnt_o and gnt_vld_o=1 the next cycle; none -> IDLE.
  - Handover latency is 2 cycles from lack_i to the next gnt_vld_o.
- cfg_tout changed mid-burst takes effect immediately, compared against the running counter.
- Counter saturates at all-ones and never wraps.
- Requests arriving during OWN are ignored until RELEASE.
- Reset asserted mid-burst: all state returns to reset values asynchronously; no tout_err_o pulse.

Decomposition:
- Package wb_arb_pkg:
  - arbiter state enum {IDLE, OWN, RELEASE}
  - localparams NUM_MST=4 and GNT_W=2
  - function for one-hot encoding of a grant index
- One combinational sub-module, wb_rr_pick:
  - inputs: req[3:0], last[1:0]
  - outputs: any, idx[1:0]
  - reused by the IDLE and RELEASE arbitration paths.

Test Plan:
- Reset then req_i=4'b0001 -> gnt_vld_o=1, gnt_o=0, gnt_oh_o=4'b0001 one cycle later; lack_i pulse -> gnt_vld_o=0 the following cycle, gnt_o stays 0.
- All 4 requesting with lack_i pulsed once per grant -> grant order 0,1,2,3,0; gnt_vld_o is low for exactly one cycle between grants.
- Master 2 owns a burst, acks on 8 consecutive cycles with no lack, master 1 requesting throughout -> gnt_o stays 2 for all 8; lack on the 8th ack -> gnt_o=3 if master 3 requests, else 1.
- cfg_tout=5, owner 1 receives no ack -> tout_err_o pulses 5 cycles after the grant, tout_id_o=1, grant released; with cfg_tout=0 the grant is held indefinitely.
- Owner drops req_i mid-burst -> RELEASE the next cycle, no tout_err_o; same-cycle lack_i and timeout -> release with tout_err_o=0.
- rst_n asserted while in OWN -> all outputs 0 asynchronously; after release of reset a new request to master 3 sees the pointer reset (req 4'b1001 grants 0 first).
